// File: rtl/uart_pkg.sv
// uart_pkg: encodings and constants shared by the configurable UART transmitter and receiver
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;
  localparam int STOP_W = 2;
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: counts clocks within a bit period and pulses bit_end_o on its last clock
module uart_bit_timer #(
  parameter int DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [DIV_W-1:0] div_i,
  input  logic             load_i,
  input  logic             en_i,
  output logic             bit_end_o
);
  logic [DIV_W-1:0] cnt_q, cnt_d, last;
  // a divisor of zero behaves as one clock per bit
  assign last = (div_i == '0) ? '0 : div_i - DIV_W'(1);
  assign bit_end_o = en_i && (cnt_q == last);
  always_comb begin
    cnt_d = (load_i || bit_end_o) ? '0 : en_i ? cnt_q + DIV_W'(1) : cnt_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: runtime-configurable UART transmitter (divisor, parity, stop bits) with valid/ready input
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 1250
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic [DIV_W-1:0]  i_clkdiv,
  input  logic [1:0]        i_parity,
  input  logic              i_stop2,
  output logic              o_uarttx,
  output logic              o_txactive,
  output logic              o_txdone
);
  localparam int IW = $clog2(DATA_W + 1);
  if (DATA_W < 5 || DATA_W > 9 || DEFAULT_DIV < 1) begin : g_bad_param
    $error("uart_tx_cfg: DATA_W must be 5..9 and DEFAULT_DIV positive");
  end
  state_e            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              par_en_q, par_en_d, par_bit_q, par_bit_d;
  logic              stop2_q, stop2_d, done_q, done_d;
  logic              accept, bit_end;
  assign o_ready    = state_q == IDLE;
  assign o_txactive = state_q != IDLE;
  assign o_txdone   = done_q;
  assign accept     = i_valid && o_ready;
  assign o_uarttx   = (state_q == START) ? 1'b0 : (state_q == DATA) ? shreg_q[0] :
                      (state_q == PARITY) ? par_bit_q : 1'b1;
  uart_bit_timer #(.DIV_W(DIV_W)) u_timer (
    .clk_i(i_clk), .rst_ni(i_rst_n), .div_i(div_q),
    .load_i(accept), .en_i(o_txactive), .bit_end_o(bit_end)
  );
  // idx_q counts data bits in DATA and extra stop bits in STOP
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    idx_d     = idx_q;
    div_d     = div_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    stop2_d   = stop2_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: if (i_valid) begin
        state_d   = START;
        shreg_d   = i_data;
        idx_d     = '0;
        div_d     = i_clkdiv;
        par_en_d  = (i_parity == PAR_EVEN) || (i_parity == PAR_ODD);
        par_bit_d = (^i_data) ^ (i_parity == PAR_ODD);
        stop2_d   = i_stop2;
      end
      START: if (bit_end) state_d = DATA;
      DATA: if (bit_end) begin
        shreg_d = shreg_q >> 1;
        idx_d   = (idx_q == IW'(DATA_W - 1)) ? '0 : idx_q + IW'(1);
        if (idx_q == IW'(DATA_W - 1)) state_d = par_en_q ? PARITY : STOP;
      end
      PARITY: if (bit_end) state_d = STOP;
      STOP: if (bit_end) begin
        if (stop2_q && idx_q < IW'(STOP_W - 1)) idx_d = idx_q + IW'(1);
        else begin
          state_d = IDLE;
          idx_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      idx_q     <= '0;
      div_q     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      idx_q     <= idx_d;
      div_q     <= div_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      stop2_q   <= stop2_d;
      done_q    <= done_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: directed checks of frame shape, handshake, config latching and reset of uart_tx_cfg
module tb_uart_tx_cfg;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [7:0]  i_data = '0;
  logic [15:0] i_clkdiv = '0;
  logic [1:0]  i_parity = '0;
  logic        i_stop2 = 1'b0;
  logic        o_uarttx, o_txactive, o_txdone;
  int          n_chk = 0;
  int          n_fail = 0;
  // per-cycle samples {line, active, done, ready}; index 0 is the first cycle after acceptance
  logic [3:0]  cap [0:255];

  uart_tx_cfg #(.DATA_W(8), .DIV_W(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .i_clkdiv(i_clkdiv), .i_parity(i_parity), .i_stop2(i_stop2),
    .o_uarttx(o_uarttx), .o_txactive(o_txactive), .o_txdone(o_txdone)
  );

  always #5 clk = ~clk;

  task automatic offer(input logic [7:0] d, input logic [15:0] div, input logic [1:0] par,
                       input logic st2, input logic hold);
    int t = 0;
    @(negedge clk);
    while (!o_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    n_chk++;
    if (o_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL offer_ready timeout: ready=%b required 1", o_ready);
    end
    i_data = d; i_clkdiv = div; i_parity = par; i_stop2 = st2; i_valid = 1'b1;
    @(posedge clk);
    #1 i_valid = hold;
  endtask

  task automatic capture(input int s, input int n);
    for (int i = s; i < s + n; i++) begin
      @(negedge clk);
      cap[i] = {o_uarttx, o_txactive, o_txdone, o_ready};
    end
  endtask

  task automatic test_reset();
    #1;
    n_chk++;
    if ({o_uarttx, o_ready, o_txactive, o_txdone} !== 4'b1100) begin
      n_fail++;
      $display("FAIL reset_state got %b required 1100", {o_uarttx, o_ready, o_txactive, o_txdone});
    end
    i_valid = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({o_uarttx, o_ready, o_txactive, o_txdone} !== 4'b1100) begin
      n_fail++;
      $display("FAIL reset_hold got %b required 1100", {o_uarttx, o_ready, o_txactive, o_txdone});
    end
    i_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_8n1();
    logic [11:0] f = {3'b111, 8'hA5, 1'b0};
    offer(8'hA5, 16'd4, 2'b00, 1'b0, 1'b0);
    capture(0, 42);
    for (int i = 0; i < 40; i++) begin
      n_chk++;
      if (cap[i] !== {f[i/4], 3'b100}) begin
        n_fail++;
        $display("FAIL 8n1 cyc%0d got %b required %b", i, cap[i], {f[i/4], 3'b100});
      end
    end
    n_chk++;
    if (cap[40] !== 4'b1011) begin n_fail++; $display("FAIL 8n1_done got %b required 1011", cap[40]); end
    n_chk++;
    if (cap[41] !== 4'b1001) begin n_fail++; $display("FAIL 8n1_idle got %b required 1001", cap[41]); end
  endtask

  task automatic test_parity();
    logic [11:0] fe = {2'b11, 1'b1, 8'h07, 1'b0};
    logic [11:0] fo = {2'b11, 1'b0, 8'h07, 1'b0};
    offer(8'h07, 16'd2, 2'b01, 1'b0, 1'b0);
    capture(0, 24);
    for (int i = 0; i < 22; i++) begin
      n_chk++;
      if (cap[i] !== {fe[i/2], 3'b100}) begin
        n_fail++;
        $display("FAIL even cyc%0d got %b required %b", i, cap[i], {fe[i/2], 3'b100});
      end
    end
    n_chk++;
    if (cap[22] !== 4'b1011) begin n_fail++; $display("FAIL even_done got %b required 1011", cap[22]); end
    offer(8'h07, 16'd2, 2'b10, 1'b0, 1'b0);
    capture(0, 24);
    for (int i = 0; i < 22; i++) begin
      n_chk++;
      if (cap[i] !== {fo[i/2], 3'b100}) begin
        n_fail++;
        $display("FAIL odd cyc%0d got %b required %b", i, cap[i], {fo[i/2], 3'b100});
      end
    end
    n_chk++;
    if (cap[22] !== 4'b1011) begin n_fail++; $display("FAIL odd_done got %b required 1011", cap[22]); end
  endtask

  task automatic test_back_to_back();
    logic [11:0] f1 = {1'b1, 2'b11, 8'h00, 1'b0};
    logic [11:0] f2 = {1'b1, 2'b11, 8'hFF, 1'b0};
    offer(8'h00, 16'd3, 2'b00, 1'b1, 1'b1);
    i_data = 8'hFF;
    capture(0, 34);
    @(posedge clk);
    #1 i_valid = 1'b0;
    capture(34, 36);
    for (int i = 0; i < 33; i++) begin
      n_chk++;
      if (cap[i] !== {f1[i/3], 3'b100}) begin
        n_fail++;
        $display("FAIL b2b_f1 cyc%0d got %b required %b", i, cap[i], {f1[i/3], 3'b100});
      end
      n_chk++;
      if (cap[34+i] !== {f2[i/3], 3'b100}) begin
        n_fail++;
        $display("FAIL b2b_f2 cyc%0d got %b required %b", i, cap[34+i], {f2[i/3], 3'b100});
      end
    end
    n_chk++;
    if (cap[33] !== 4'b1011) begin n_fail++; $display("FAIL b2b_done1 got %b required 1011", cap[33]); end
    n_chk++;
    if (cap[67] !== 4'b1011) begin n_fail++; $display("FAIL b2b_done2 got %b required 1011", cap[67]); end
    n_chk++;
    if (cap[68] !== 4'b1001) begin n_fail++; $display("FAIL b2b_idle got %b required 1001", cap[68]); end
  endtask

  task automatic test_div01();
    logic [11:0] fa = {2'b11, 8'h3C, 1'b0};
    logic [11:0] fb = {2'b11, 8'hC3, 1'b0};
    offer(8'h3C, 16'd0, 2'b00, 1'b0, 1'b0);
    capture(0, 12);
    for (int i = 0; i < 10; i++) begin
      n_chk++;
      if (cap[i] !== {fa[i], 3'b100}) begin
        n_fail++;
        $display("FAIL div0 cyc%0d got %b required %b", i, cap[i], {fa[i], 3'b100});
      end
    end
    n_chk++;
    if (cap[10] !== 4'b1011) begin n_fail++; $display("FAIL div0_done got %b required 1011", cap[10]); end
    offer(8'hC3, 16'd1, 2'b11, 1'b0, 1'b0);
    capture(0, 12);
    for (int i = 0; i < 10; i++) begin
      n_chk++;
      if (cap[i] !== {fb[i], 3'b100}) begin
        n_fail++;
        $display("FAIL div1 cyc%0d got %b required %b", i, cap[i], {fb[i], 3'b100});
      end
    end
    n_chk++;
    if (cap[10] !== 4'b1011) begin n_fail++; $display("FAIL div1_done got %b required 1011", cap[10]); end
  endtask

  task automatic test_midframe_cfg();
    logic [11:0] f1 = {3'b111, 8'h5A, 1'b0};
    logic [11:0] f2 = {1'b1, 1'b1, 8'h81, 1'b0};
    offer(8'h5A, 16'd4, 2'b00, 1'b0, 1'b0);
    capture(0, 10);
    i_clkdiv = 16'd8; i_parity = 2'b10; i_data = 8'h81; i_valid = 1'b1;
    capture(10, 31);
    @(posedge clk);
    #1 i_valid = 1'b0;
    capture(41, 90);
    for (int i = 0; i < 40; i++) begin
      n_chk++;
      if (cap[i] !== {f1[i/4], 3'b100}) begin
        n_fail++;
        $display("FAIL mid_f1 cyc%0d got %b required %b", i, cap[i], {f1[i/4], 3'b100});
      end
    end
    n_chk++;
    if (cap[40] !== 4'b1011) begin n_fail++; $display("FAIL mid_done1 got %b required 1011", cap[40]); end
    for (int i = 0; i < 88; i++) begin
      n_chk++;
      if (cap[41+i] !== {f2[i/8], 3'b100}) begin
        n_fail++;
        $display("FAIL mid_f2 cyc%0d got %b required %b", i, cap[41+i], {f2[i/8], 3'b100});
      end
    end
    n_chk++;
    if (cap[129] !== 4'b1011) begin n_fail++; $display("FAIL mid_done2 got %b required 1011", cap[129]); end
    n_chk++;
    if (cap[130] !== 4'b1001) begin n_fail++; $display("FAIL mid_idle got %b required 1001", cap[130]); end
  endtask

  task automatic test_reset_midframe();
    logic [11:0] f = {2'b11, 1'b0, 8'h96, 1'b0};
    offer(8'h96, 16'd4, 2'b00, 1'b0, 1'b0);
    capture(0, 18);
    n_chk++;
    if (cap[17] !== 4'b0100) begin n_fail++; $display("FAIL rstmid_pre got %b required 0100", cap[17]); end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({o_uarttx, o_ready, o_txactive, o_txdone} !== 4'b1100) begin
      n_fail++;
      $display("FAIL rstmid_async got %b required 1100", {o_uarttx, o_ready, o_txactive, o_txdone});
    end
    capture(18, 3);
    for (int i = 18; i < 21; i++) begin
      n_chk++;
      if (cap[i] !== 4'b1001) begin n_fail++; $display("FAIL rstmid_hold cyc%0d got %b required 1001", i, cap[i]); end
    end
    rst_n = 1'b1;
    offer(8'h96, 16'd2, 2'b01, 1'b0, 1'b0);
    capture(0, 24);
    for (int i = 0; i < 22; i++) begin
      n_chk++;
      if (cap[i] !== {f[i/2], 3'b100}) begin
        n_fail++;
        $display("FAIL rstmid_next cyc%0d got %b required %b", i, cap[i], {f[i/2], 3'b100});
      end
    end
    n_chk++;
    if (cap[22] !== 4'b1011) begin n_fail++; $display("FAIL rstmid_done got %b required 1011", cap[22]); end
    n_chk++;
    if (cap[23] !== 4'b1001) begin n_fail++; $display("FAIL rstmid_idle got %b required 1001", cap[23]); end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_back_to_back();
    test_div01();
    test_midframe_cfg();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
